dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the MEM stage and main memory.
- Drives the `miss` input of the hazard unit. While `miss` is high, the hazard unit freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Hits complete combinationally in the MEM cycle. Misses run a line writeback (if dirty) and a refill over a word-wide memory handshake.

---
 rtl/dcache_ctrl_pkg.sv | 20 ++
 rtl/dcache_array.sv | 54 +++++
 rtl/dcache_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data cache: FSM state encodings, default geometry
// and the tag-width derivation used by the controller and its storage array.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_INDEX_W    = 6;
  localparam int DEF_OFFSET_W   = 4;
  localparam int DEF_LINE_WORDS = 4;

  function automatic int tag_width(input int addr_w, input int index_w, input int offset_w);
    return addr_w - index_w - offset_w;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Direct-mapped line storage: synchronous write, asynchronous read of the
// addressed set's valid/dirty/tag and whole data line.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int INDEX_W    = DEF_INDEX_W,
  parameter int TAG_W      = tag_width(DEF_ADDR_W, DEF_INDEX_W, DEF_OFFSET_W),
  parameter int WORD_W     = DEF_OFFSET_W - 2,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                         clk,
  input  logic                         clear_all,
  input  logic [INDEX_W-1:0]           index,
  input  logic [WORD_W-1:0]            word_sel,
  input  logic                         word_we,
  input  logic [31:0]                  word_wdata,
  input  logic                         meta_we,
  input  logic [TAG_W-1:0]             meta_tag,
  input  logic                         meta_dirty,
  output logic                         rd_valid,
  output logic                         rd_dirty,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [LINE_WORDS-1:0][31:0]  rd_line
);

  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]             valid_q;
  logic [SETS-1:0]             dirty_q;
  logic [TAG_W-1:0]            tag_q  [SETS];
  logic [LINE_WORDS-1:0][31:0] data_q [SETS];

  // Only valid/dirty are cleared; tag and data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (clear_all) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (meta_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= meta_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (meta_we) tag_q[index] <= meta_tag;
    if (word_we) data_q[index][word_sel] <= word_wdata;
  end

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_line  = data_q[index];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped D-cache controller with word-wide
// memory handshake. DCACHE_STATS_EN adds hit_cnt/miss_cnt outputs.
//   state    | meaning
//   S_IDLE   | serve hits combinationally, launch WB or REFILL on a miss
//   S_WB     | write the dirty victim line out, one beat per mem_ready
//   S_REFILL | fetch the requested line, install tag/valid on last beat
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int INDEX_W    = DEF_INDEX_W,
  parameter int OFFSET_W   = DEF_OFFSET_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              miss,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int TAG_W  = tag_width(ADDR_W, INDEX_W, OFFSET_W);
  localparam int WORD_W = OFFSET_W - 2;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  state_t                      state;
  logic [WORD_W-1:0]           beat;
  logic [WORD_W-1:0]           beat_nxt;
  logic [TAG_W-1:0]            cpu_tag;
  logic [INDEX_W-1:0]          index;
  logic [WORD_W-1:0]           cpu_word;
  logic                        access;
  logic                        hit;
  logic                        idle;
  logic                        beat_done;
  logic                        rd_valid;
  logic                        rd_dirty;
  logic [TAG_W-1:0]            rd_tag;
  logic [LINE_WORDS-1:0][31:0] rd_line;
  logic                        word_we;
  logic [WORD_W-1:0]           word_sel;
  logic [31:0]                 word_wdata;
  logic                        meta_we;
  logic [TAG_W-1:0]            meta_tag;
  logic                        meta_dirty;
  logic                        unused_addr_lsb;

  assign cpu_tag         = cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign index           = cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign cpu_word        = cpu_addr[OFFSET_W-1:2];
  assign unused_addr_lsb = &{1'b0, cpu_addr[1:0]};

  assign access    = cpu_re | cpu_we;
  assign idle      = (state == S_IDLE);
  assign hit       = rd_valid && (rd_tag == cpu_tag);
  assign beat_done = mem_req && mem_ready;
  assign beat_nxt  = beat + 1'b1;

  assign miss      = !idle || (access && !hit);
  assign cpu_rdata = (idle && hit) ? rd_line[cpu_word] : '0;

  always_comb begin
    word_we    = 1'b0;
    word_sel   = cpu_word;
    word_wdata = cpu_wdata;
    meta_we    = 1'b0;
    meta_tag   = rd_tag;
    meta_dirty = 1'b1;
    if (!rst) begin
      if (idle && cpu_we && hit) begin
        word_we = 1'b1;
        meta_we = 1'b1;
      end else if (state == S_REFILL && beat_done) begin
        word_we    = 1'b1;
        word_sel   = beat;
        word_wdata = mem_rdata;
        if (beat == LAST_BEAT) begin
          meta_we    = 1'b1;
          meta_tag   = cpu_tag;
          meta_dirty = 1'b0;
        end
      end
    end
  end

  dcache_array #(
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W),
    .WORD_W    (WORD_W),
    .LINE_WORDS(LINE_WORDS)
  ) u_array (
    .clk       (clk),
    .clear_all (rst),
    .index     (index),
    .word_sel  (word_sel),
    .word_we   (word_we),
    .word_wdata(word_wdata),
    .meta_we   (meta_we),
    .meta_tag  (meta_tag),
    .meta_dirty(meta_dirty),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line)
  );

  // The victim tag stays readable through WB because the tag is only rewritten at refill end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access && !hit) begin
            mem_req <= 1'b1;
            beat    <= '0;
            if (rd_valid && rd_dirty) begin
              state     <= S_WB;
              mem_we    <= 1'b1;
              mem_addr  <= {rd_tag, index, {WORD_W{1'b0}}, 2'b00};
              mem_wdata <= rd_line[0];
            end else begin
              state    <= S_REFILL;
              mem_we   <= 1'b0;
              mem_addr <= {cpu_tag, index, {WORD_W{1'b0}}, 2'b00};
            end
          end
        end
        S_WB: begin
          if (beat_done) begin
            if (beat == LAST_BEAT) begin
              state     <= S_REFILL;
              beat      <= '0;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              mem_addr  <= {cpu_tag, index, {WORD_W{1'b0}}, 2'b00};
            end else begin
              beat      <= beat_nxt;
              mem_addr  <= {rd_tag, index, beat_nxt, 2'b00};
              mem_wdata <= rd_line[beat_nxt];
            end
          end
        end
        S_REFILL: begin
          if (beat_done) begin
            if (beat == LAST_BEAT) begin
              state    <= S_IDLE;
              beat     <= '0;
              mem_req  <= 1'b0;
              mem_addr <= '0;
            end else begin
              beat     <= beat_nxt;
              mem_addr <= {cpu_tag, index, beat_nxt, 2'b00};
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (idle && access) begin
      if (hit) hit_cnt  <= hit_cnt + 1'b1;
      else     miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold refill, hit table, dirty writeback,
// stalled memory and reset mid-refill, with an optional statistics check.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        miss;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_re   (cpu_re),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .miss     (miss),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Memory model: read data from a preloaded table, ready after wait_n stall cycles.
  logic [31:0] mem_model [1024];
  int          wait_n = 0;
  int          wcnt = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] rd_addr_q[$];

  assign mem_rdata = mem_model[mem_addr[11:2]];
  assign mem_ready = mem_req && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else                       wcnt <= 0;
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
      end else begin
        rd_addr_q.push_back(mem_addr);
      end
    end
  end

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts cycles with miss=1 from the current sample point until miss drops,
  // and counts any change of mem_* while a beat is stalled.
  task automatic run_miss(input string name, input int exp_cycles, output int viol);
    int          n;
    bit          done;
    logic        p_req, p_we, p_rdy, p_ok;
    logic [31:0] p_addr;
    n = 0; done = 0; viol = 0; p_ok = 0;
    p_req = 0; p_we = 0; p_rdy = 0; p_addr = '0;
    for (int i = 0; i < 200; i++) begin
      if (p_ok && p_req && !p_rdy &&
          (mem_req !== p_req || mem_we !== p_we || mem_addr !== p_addr)) viol++;
      if (!miss) begin
        done = 1;
        break;
      end
      p_ok = 1; p_req = mem_req; p_we = mem_we; p_rdy = mem_ready; p_addr = mem_addr;
      n++;
      @(posedge clk); #2;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: miss still high after %0d cycles, required low", name, n);
    end
    chk({name, " miss cycles"}, n, exp_cycles);
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          viol;
    logic [31:0] exp_wd [4];

    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      mem_model[16 + i]  = 32'h11 * (i + 1);
      mem_model[272 + i] = 32'hA0 + i;
      mem_model[32 + i]  = 32'hB0 + i;
      mem_model[48 + i]  = 32'hC0 + i;
    end

    vecs[0] = '{1'b1, 1'b0, 32'h48, 32'h0,          1'b1, 32'h33};
    vecs[1] = '{1'b1, 1'b0, 32'h40, 32'h0,          1'b1, 32'h11};
    vecs[2] = '{1'b1, 1'b0, 32'h4C, 32'h0,          1'b1, 32'h44};
    vecs[3] = '{1'b0, 1'b1, 32'h44, 32'hDEADBEEF,   1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h44, 32'h0,          1'b1, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h47, 32'h0,          1'b1, 32'hDEADBEEF};
    vecs[6] = '{1'b1, 1'b1, 32'h48, 32'h12345678,   1'b0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h48, 32'h0,          1'b1, 32'h12345678};
    vecs[8] = '{1'b0, 1'b0, 32'h444, 32'h0,         1'b0, 32'h0};
    exp_wd[0] = 32'h11; exp_wd[1] = 32'hDEADBEEF; exp_wd[2] = 32'h12345678; exp_wd[3] = 32'h44;

    rst = 1'b1; cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset miss", miss, 0);
    chk("reset cpu_rdata", cpu_rdata, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);

    // Cold load: refill only, 5 miss cycles.
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    drive(1, 0, 32'h40, 0);
    run_miss("cold", 5, viol);
    chk("cold rdata", cpu_rdata, 32'h11);
    chk("cold read beats", rd_addr_q.size(), 4);
    chk("cold write beats", wr_addr_q.size(), 0);
    if (rd_addr_q.size() == 4)
      for (int i = 0; i < 4; i++) chk($sformatf("cold beat%0d addr", i), rd_addr_q[i], 32'h40 + 4 * i);
    exp_hits++; exp_misses++;

    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].re, vecs[v].we, vecs[v].addr, vecs[v].wdata);
      chk($sformatf("vec%0d miss", v), miss, 0);
      chk($sformatf("vec%0d mem_req", v), mem_req, 0);
      if (vecs[v].chk_rd) chk($sformatf("vec%0d rdata", v), cpu_rdata, vecs[v].exp_rd);
      if (vecs[v].re || vecs[v].we) exp_hits++;
    end
    chk("hits no traffic", rd_addr_q.size(), 4);

    // Dirty victim: 4 write beats, then 4 read beats of the new tag.
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    drive(1, 0, 32'h444, 0);
    run_miss("wb", 9, viol);
    chk("wb rdata", cpu_rdata, 32'hA1);
    chk("wb write beats", wr_addr_q.size(), 4);
    chk("wb read beats", rd_addr_q.size(), 4);
    if (wr_addr_q.size() == 4 && rd_addr_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("wb beat%0d addr", i), wr_addr_q[i], 32'h40 + 4 * i);
        chk($sformatf("wb beat%0d data", i), wr_data_q[i], exp_wd[i]);
        chk($sformatf("wb refill%0d addr", i), rd_addr_q[i], 32'h440 + 4 * i);
      end
    exp_hits++; exp_misses++;

    // Memory stalls 3 cycles per beat.
    wait_n = 3;
    drive(1, 0, 32'h88, 0);
    run_miss("stall", 17, viol);
    chk("stall outputs held", viol, 0);
    chk("stall rdata", cpu_rdata, 32'hB2);
    wait_n = 0;
    exp_hits++; exp_misses++;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 32'h80 + 4 * i, 0);
      chk($sformatf("stall line word%0d miss", i), miss, 0);
      chk($sformatf("stall line word%0d", i), cpu_rdata, 32'hB0 + i);
      exp_hits++;
    end

    drive(0, 0, 32'h0, 0);
`ifdef DCACHE_STATS_EN
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
`endif

    // Reset during refill beat 2.
    drive(1, 0, 32'hC0, 0);
    chk("rst-seq miss", miss, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst-seq beat2 addr", mem_addr, 32'hC8);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cpu_re = 0;
    #1;
    chk("rst-seq mem_req dropped", mem_req, 0);
    chk("rst-seq mem_addr", mem_addr, 0);
    chk("rst-seq idle miss", miss, 0);
    exp_hits = 0; exp_misses = 0;

    drive(1, 0, 32'h84, 0);
    chk("post-rst 0x84 invalid", miss, 1);
    run_miss("post-rst 0x84", 5, viol);
    chk("post-rst 0x84 rdata", cpu_rdata, 32'hB1);
    exp_hits++; exp_misses++;

    drive(1, 0, 32'hC4, 0);
    run_miss("post-rst 0xC4", 5, viol);
    chk("post-rst 0xC4 rdata", cpu_rdata, 32'hC1);
    exp_hits++; exp_misses++;

    drive(0, 0, 32'h0, 0);
`ifdef DCACHE_STATS_EN
    chk("hit_cnt after rst", hit_cnt, exp_hits);
    chk("miss_cnt after rst", miss_cnt, exp_misses);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
